// File: rtl/inst_mem_pkg.sv
// Shared constants and state encoding for the instruction fetch memory.
// Imported by the storage array and the fetch front end.
package inst_mem_pkg;

    localparam int ADDR_W_DEF = 5;

    localparam logic [31:0] NOP = 32'h0000_0000;

    typedef logic [0:0] state_t;

    localparam state_t ST_BOOT = 1'b0;
    localparam state_t ST_RUN  = 1'b1;

endpackage

// File: rtl/inst_mem_array.sv
// Instruction storage with per-word written bits and one registered read port.
// A read of the word being written in the same cycle returns the new data.
module inst_mem_array
    import inst_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RST_n,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_rwritten
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]  r_written;
    logic [DATA_W-1:0] r_rdata;
    logic              r_rwritten;
    logic              w_hit;

    assign w_hit = i_we && (i_waddr == i_raddr);

    // Contents survive reset; only the written bits are cleared.
    always_ff @(posedge CLK) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_written  <= '0;
            r_rdata    <= '0;
            r_rwritten <= 1'b0;
        end else begin
            if (i_we) begin
                r_written[i_waddr] <= 1'b1;
            end
            if (i_re) begin
                r_rdata    <= w_hit ? i_wdata : r_mem[i_raddr];
                r_rwritten <= w_hit | r_written[i_raddr];
            end
        end
    end

    assign o_rdata    = r_rdata;
    assign o_rwritten = r_rwritten;

endmodule

// File: rtl/inst_fetch_mem.sv
// Fetch front end: boot/run FSM, address checking and valid/ready handshake.
// The array read registers double as the stall hold register.
module inst_fetch_mem
    import inst_mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RST_n,
    input  logic              Req,
    input  logic [31:0]       Addr,
    output logic              Ready,
    input  logic              Stall,
    output logic [DATA_W-1:0] Inst,
    output logic              InstValid,
    output logic              Fault,
    input  logic              LdEn,
    input  logic [ADDR_W-1:0] LdAddr,
    input  logic [DATA_W-1:0] LdData,
    input  logic              LdDone,
    output logic              Booted
);

    state_t            r_state;
    logic              r_valid;
    logic              r_fault;
    logic              w_booted;
    logic              w_accept;
    logic              w_bad;
    logic [ADDR_W-1:0] w_idx;
    logic [DATA_W-1:0] w_rdata;
    logic              w_rwritten;

    assign w_booted = (r_state == ST_RUN);
    assign Ready    = w_booted & ~(r_valid & Stall);
    assign w_accept = Req & Ready;
    assign w_idx    = Addr[ADDR_W+1:2];
    assign w_bad    = (|Addr[1:0]) | (|Addr[31:ADDR_W+2]);

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_state <= ST_BOOT;
        end else if (r_state == ST_BOOT && LdDone) begin
            r_state <= ST_RUN;
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_valid <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            r_valid <= w_accept | (r_valid & Stall);
            if (w_accept) begin
                r_fault <= w_bad;
            end
        end
    end

    inst_mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .CLK        (CLK),
        .RST_n      (RST_n),
        .i_we       (LdEn),
        .i_waddr    (LdAddr),
        .i_wdata    (LdData),
        .i_re       (w_accept),
        .i_raddr    (w_idx),
        .o_rdata    (w_rdata),
        .o_rwritten (w_rwritten)
    );

    always_comb begin
        Inst = '0;
        if (r_valid && !r_fault) begin
            Inst = w_rwritten ? w_rdata : DATA_W'(NOP);
        end
    end

    assign InstValid = r_valid;
    assign Fault     = r_valid & r_fault;
    assign Booted    = w_booted;

endmodule

// File: tb/tb_inst_fetch_mem.sv
// Randomized and directed bench for inst_fetch_mem against a word-level model.
// The model tracks memory, loaded words, boot state and the pending response.
module tb_inst_fetch_mem;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int DEPTH = 1 << AW;

    logic          CLK = 1'b0;
    logic          RST_n;
    logic          Req;
    logic [31:0]   Addr;
    logic          Ready;
    logic          Stall;
    logic [DW-1:0] Inst;
    logic          InstValid;
    logic          Fault;
    logic          LdEn;
    logic [AW-1:0] LdAddr;
    logic [DW-1:0] LdData;
    logic          LdDone;
    logic          Booted;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_mem [DEPTH];
    bit          m_wr  [DEPTH];
    bit          m_boot;
    bit          m_valid;
    bit          m_fault;
    logic [31:0] m_inst;

    inst_fetch_mem #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .CLK       (CLK),
        .RST_n     (RST_n),
        .Req       (Req),
        .Addr      (Addr),
        .Ready     (Ready),
        .Stall     (Stall),
        .Inst      (Inst),
        .InstValid (InstValid),
        .Fault     (Fault),
        .LdEn      (LdEn),
        .LdAddr    (LdAddr),
        .LdData    (LdData),
        .LdDone    (LdDone),
        .Booted    (Booted)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        foreach (m_wr[i]) m_wr[i] = 1'b0;
        m_boot  = 1'b0;
        m_valid = 1'b0;
        m_fault = 1'b0;
        m_inst  = '0;
    endtask

    task automatic chk_outs(input string tag);
        chk({tag, ".valid"}, 32'(InstValid), 32'(m_valid));
        chk({tag, ".booted"}, 32'(Booted), 32'(m_boot));
        if (m_valid) begin
            chk({tag, ".inst"}, Inst, m_inst);
            chk({tag, ".fault"}, 32'(Fault), 32'(m_fault));
        end
    endtask

    // One clock: drive inputs, check Ready, advance model and DUT, check outputs.
    task automatic cyc(input bit req, input logic [31:0] addr, input bit stall,
                       input bit lden, input logic [AW-1:0] la,
                       input logic [31:0] ld, input bit done);
        bit acc;
        int idx;
        Req = req; Addr = addr; Stall = stall;
        LdEn = lden; LdAddr = la; LdData = ld; LdDone = done;
        #1;
        chk("ready", 32'(Ready), 32'(m_boot && !(m_valid && stall)));
        acc = req && m_boot && !(m_valid && stall);
        @(posedge CLK);
        if (lden) begin
            m_mem[la] = ld;
            m_wr[la]  = 1'b1;
        end
        if (acc) begin
            m_valid = 1'b1;
            if (addr[1:0] != 2'b00 || addr >= 32'(4 * DEPTH)) begin
                m_fault = 1'b1;
                m_inst  = '0;
            end else begin
                idx     = int'(addr) / 4;
                m_fault = 1'b0;
                m_inst  = m_wr[idx] ? m_mem[idx] : 32'h0;
            end
        end else if (!(m_valid && stall)) begin
            m_valid = 1'b0;
        end
        if (done) m_boot = 1'b1;
        #1;
        chk_outs("cyc");
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, ".inst"}, Inst, 32'h0);
        chk({tag, ".valid"}, 32'(InstValid), 32'h0);
        chk({tag, ".fault"}, 32'(Fault), 32'h0);
        chk({tag, ".ready"}, 32'(Ready), 32'h0);
        chk({tag, ".booted"}, 32'(Booted), 32'h0);
    endtask

    task automatic do_reset();
        Req = 0; Addr = 0; Stall = 0; LdEn = 0;
        LdAddr = 0; LdData = 0; LdDone = 0;
        #2 RST_n = 1'b0;
        #1;
        chk_reset_outs("rst");
        model_clear();
        @(negedge CLK);
        @(negedge CLK);
        RST_n = 1'b1;
        @(posedge CLK);
        #1;
    endtask

    logic [31:0] ra;
    int          sel;

    initial begin
        RST_n = 1'b1;
        foreach (m_mem[i]) m_mem[i] = 'x;
        model_clear();
        do_reset();

        for (int i = 0; i < 4; i++) cyc(1, 32'h0, 0, 0, 0, 0, 0);
        chk("boot.booted", 32'(Booted), 32'h0);

        cyc(0, 0, 0, 1, 5'd0, 32'h20010008, 0);
        cyc(1, 0, 0, 1, 5'd1, 32'h3402000C, 1);
        chk("boot.novalid", 32'(InstValid), 32'h0);
        cyc(1, 32'h0, 0, 0, 0, 0, 0);
        chk("ld.w0", Inst, 32'h20010008);
        cyc(1, 32'h4, 0, 0, 0, 0, 0);
        chk("ld.w1", Inst, 32'h3402000C);
        chk("ld.v1", 32'(InstValid), 32'h1);

        cyc(1, 32'h8, 0, 0, 0, 0, 0);
        chk("unw.inst", Inst, 32'h0);
        cyc(1, 32'h2, 0, 0, 0, 0, 0);
        chk("mis.fault", 32'(Fault), 32'h1);
        cyc(1, 32'h80, 0, 0, 0, 0, 0);
        chk("oor.fault", 32'(Fault), 32'h1);

        cyc(1, 32'h0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 32'h4, 1, 1, 5'd0, 32'hDEADBEEF, 0);
            chk("stall.inst", Inst, 32'h20010008);
        end
        cyc(0, 0, 0, 0, 0, 0, 0);
        cyc(1, 32'h0, 0, 0, 0, 0, 0);
        chk("stall.new", Inst, 32'hDEADBEEF);

        cyc(1, 32'h14, 0, 1, 5'd5, 32'h00221820, 0);
        chk("coll.inst", Inst, 32'h00221820);

        cyc(1, 32'h0, 0, 0, 0, 0, 0);
        chk("mid.valid", 32'(InstValid), 32'h1);
        do_reset();
        for (int i = 0; i < 3; i++) cyc(1, 32'h0, 0, 0, 0, 0, 0);
        cyc(1, 32'h0, 0, 0, 0, 0, 1);
        cyc(1, 32'h0, 0, 0, 0, 0, 0);
        chk("mid.nop", Inst, 32'h0);
        chk("mid.fault", 32'(Fault), 32'h0);

        for (int i = 0; i < 400; i++) begin
            sel = $urandom_range(0, 9);
            if (sel < 7)      ra = 32'($urandom_range(0, DEPTH - 1)) << 2;
            else if (sel < 9) ra = 32'($urandom_range(0, 4 * DEPTH - 1));
            else              ra = $urandom;
            cyc($urandom_range(0, 3) != 0, ra, $urandom_range(0, 9) < 3,
                $urandom_range(0, 9) < 4, AW'($urandom), $urandom,
                $urandom_range(0, 19) == 0);
            if (i == 200) do_reset();
        end

        idle(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
